// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, RAM port arbitration, prefetch queue, IR handshake
// Optional FETCH_STAGE_PERF_EN adds a saturating pop counter on fetch_cnt.
module fetch_stage #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    PF_DEPTH   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  dsel,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic                  branch,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic [DATA_WIDTH-1:0] ir,
  output logic [ADDR_WIDTH-1:0] ir_pc,
  output logic                  ir_valid,
  input  logic                  ir_ready
`ifdef FETCH_STAGE_PERF_EN
  ,
  output logic [15:0]           fetch_cnt
`endif
);

  localparam int PW = (PF_DEPTH > 1) ? $clog2(PF_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, BUSY, KILL} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] tag_q, tag_d;
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] q_ir_q [PF_DEPTH];
  logic [ADDR_WIDTH-1:0] q_pc_q [PF_DEPTH];
  logic [DATA_WIDTH-1:0] hold_ir_q;
  logic [ADDR_WIDTH-1:0] hold_pc_q;

  logic resp_vld, q_empty, space, pop, push, deq;

  always_comb begin
    resp_vld = (state_q == BUSY);
    q_empty  = (count_q == '0);
    space    = (count_q + CW'(resp_vld)) < CW'(PF_DEPTH);
    mem_addr = dsel ? daddr : pc_q;
    mem_rd   = reset && !dsel && !branch && space;
    ir_valid = !q_empty || resp_vld;
    // An arriving word is presented straight to decode when the queue is empty.
    if (!q_empty) begin
      ir    = q_ir_q[head_q];
      ir_pc = q_pc_q[head_q];
    end else if (resp_vld) begin
      ir    = mem_rdata;
      ir_pc = tag_q;
    end else begin
      ir    = hold_ir_q;
      ir_pc = hold_pc_q;
    end
    pop  = ir_valid && ir_ready && !branch;
    push = resp_vld && !branch && !(pop && q_empty);
    deq  = pop && !q_empty;

    pc_d    = pc_q;
    tag_d   = tag_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CW'(push) - CW'(deq);
    if (push) tail_d = tail_q + PW'(1);
    if (deq)  head_d = head_q + PW'(1);
    if (mem_rd) begin
      pc_d  = pc_q + ADDR_WIDTH'(1);
      tag_d = pc_q;
    end
    if (branch) begin
      pc_d    = branch_target;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end

    state_d = mem_rd ? BUSY : IDLE;
    if (branch) state_d = (state_q == BUSY) ? KILL : IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      tag_q     <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      hold_ir_q <= '0;
      hold_pc_q <= '0;
      for (int i = 0; i < PF_DEPTH; i++) begin
        q_ir_q[i] <= '0;
        q_pc_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tag_q   <= tag_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (ir_valid) begin
        hold_ir_q <= ir;
        hold_pc_q <= ir_pc;
      end
      if (push) begin
        q_ir_q[tail_q] <= mem_rdata;
        q_pc_q[tail_q] <= tag_q;
      end
    end
  end

`ifdef FETCH_STAGE_PERF_EN
  logic [15:0] fetch_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt_q <= '0;
    end else if (pop && fetch_cnt_q != 16'hFFFF) begin
      fetch_cnt_q <= fetch_cnt_q + 16'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
`endif

endmodule
